mc_main_controller: RTL and testbench

//  Multicycle MIPS main control FSM. Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB.

---
 rtl/mips_ctrl_pkg.sv | 60 ++++++
 rtl/mc_main_controller_if.sv | 28 ++
 rtl/mc_ctrl_outdec.sv | 72 +++++++
 rtl/mc_main_controller.sv | 70 +++++++
 tb/tb_mc_main_controller.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: states, opcodes, select codes, control word.
// The BNE state and branchn bit are only live when MC_CTRL_BNE_EN is defined.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BEQ     = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11,
      BNE     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
`ifdef MC_CTRL_BNE_EN
      logic       branchn;
`endif
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       iord;
      logic       memtoreg;
      logic       regdst;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
   } ctrl_t;

endpackage

// File: rtl/mc_main_controller_if.sv
// Controller <-> datapath bundle: opcode and zero flag in, enables and mux selects out.
interface mc_main_controller_if;
   logic [5:0] op;
   logic       zero;
   logic       pcen;
   logic       irwrite;
   logic       memwrite;
   logic       regwrite;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [1:0] aluop;

   // master is the datapath side, slave is the controller
   modport master (
      output op, zero,
      input  pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
             alusrca, alusrcb, pcsrc, aluop
   );
   modport slave (
      input  op, zero,
      output pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst,
             alusrca, alusrcb, pcsrc, aluop
   );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: state -> control word. Unlisted fields and illegal states decode to all zero.
// BNE state decoded only when MC_CTRL_BNE_EN is defined.
module mc_ctrl_outdec
   import mips_ctrl_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.irwrite = 1'b1;
            ctrl.pcwrite = 1'b1;
            ctrl.alusrcb = SRCB_FOUR;
            ctrl.aluop   = ALUOP_ADD;
         end
         // branch target is precomputed into ALUOut here
         DECODE: begin
            ctrl.alusrcb = SRCB_IMMSH;
            ctrl.aluop   = ALUOP_ADD;
         end
         MEMADR: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
         end
         MEMRD: ctrl.iord = 1'b1;
         MEMWB: begin
            ctrl.memtoreg = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         MEMWR: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         EXECUTE: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         ALUWB: begin
            ctrl.regdst   = 1'b1;
            ctrl.regwrite = 1'b1;
         end
         BEQ: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALUOP_SUB;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.branch  = 1'b1;
         end
         ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
         end
         ADDIWB: ctrl.regwrite = 1'b1;
         JUMP: begin
            ctrl.pcsrc   = PCSRC_JUMP;
            ctrl.pcwrite = 1'b1;
         end
`ifdef MC_CTRL_BNE_EN
         BNE: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALUOP_SUB;
            ctrl.pcsrc   = PCSRC_ALUOUT;
            ctrl.branchn = 1'b1;
         end
`endif
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_main_controller.sv
// Multicycle MIPS main control FSM: next-state logic, state register, pcen and reset gating of writes.
// Define MC_CTRL_BNE_EN to add the bne instruction; otherwise bne decodes as a NOP.
module mc_main_controller
   import mips_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   mc_main_controller_if.slave  bus
);

   state_t state, state_nxt;
   ctrl_t  ctrl;
   logic   pcen_raw;

   always_comb begin
      state_nxt = FETCH;
      case (state)
         FETCH: state_nxt = DECODE;
         DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: state_nxt = MEMADR;
               OP_RTYPE:     state_nxt = EXECUTE;
               OP_BEQ:       state_nxt = BEQ;
               OP_ADDI:      state_nxt = ADDIEX;
               OP_J:         state_nxt = JUMP;
`ifdef MC_CTRL_BNE_EN
               OP_BNE:       state_nxt = BNE;
`endif
               default:      state_nxt = FETCH;
            endcase
         end
         // op is held stable through the instruction, so it still selects load vs store here
         MEMADR:  state_nxt = (bus.op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   state_nxt = MEMWB;
         EXECUTE: state_nxt = ALUWB;
         ADDIEX:  state_nxt = ADDIWB;
         default: state_nxt = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   mc_ctrl_outdec u_outdec (
      .state (state),
      .ctrl  (ctrl)
   );

`ifdef MC_CTRL_BNE_EN
   assign pcen_raw = ctrl.pcwrite | (ctrl.branch & bus.zero) | (ctrl.branchn & ~bus.zero);
`else
   assign pcen_raw = ctrl.pcwrite | (ctrl.branch & bus.zero);
`endif

   // reset abandons the instruction: no architectural write during the reset cycle
   assign bus.pcen     = pcen_raw      & ~reset;
   assign bus.irwrite  = ctrl.irwrite  & ~reset;
   assign bus.memwrite = ctrl.memwrite & ~reset;
   assign bus.regwrite = ctrl.regwrite & ~reset;
   assign bus.iord     = ctrl.iord;
   assign bus.memtoreg = ctrl.memtoreg;
   assign bus.regdst   = ctrl.regdst;
   assign bus.alusrca  = ctrl.alusrca;
   assign bus.alusrcb  = ctrl.alusrcb;
   assign bus.pcsrc    = ctrl.pcsrc;
   assign bus.aluop    = ctrl.aluop;

endmodule

// File: tb/tb_mc_main_controller.sv
// Scoreboard bench for mc_main_controller: per-instruction reference model feeds a queue, a negedge monitor checks.
// Honours MC_CTRL_BNE_EN the same way as the design.
module tb_mc_main_controller;

   localparam logic [5:0] T_RTYPE = 6'b000000;
   localparam logic [5:0] T_LW    = 6'b100011;
   localparam logic [5:0] T_SW    = 6'b101011;
   localparam logic [5:0] T_BEQ   = 6'b000100;
   localparam logic [5:0] T_ADDI  = 6'b001000;
   localparam logic [5:0] T_J     = 6'b000010;
   localparam logic [5:0] T_BNE   = 6'b000101;

   typedef struct packed {
      logic       pcen;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       iord;
      logic       memtoreg;
      logic       regdst;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
   } obs_t;

   typedef struct {
      obs_t       o;
      logic [5:0] op;
      int         k;
      logic       rst;
   } exp_t;

   logic clk;
   logic reset;
   mc_main_controller_if bus ();

   mc_main_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // instruction length in cycles, from the published cycle counts
   function automatic int ref_len(input logic [5:0] op);
      case (op)
         T_LW:                   return 5;
         T_SW, T_RTYPE, T_ADDI:  return 4;
         T_BEQ, T_J:             return 3;
`ifdef MC_CTRL_BNE_EN
         T_BNE:                  return 3;
`endif
         default:                return 2;
      endcase
   endfunction

   // expected datapath controls in step k of an instruction with opcode op
   function automatic obs_t ref_out(input logic [5:0] op, input int k, input logic z);
      obs_t o = '0;
      if (k == 0) begin
         o.pcen = 1'b1; o.irwrite = 1'b1; o.alusrcb = 2'b01;
      end else if (k == 1) begin
         o.alusrcb = 2'b11;
      end else begin
         case (op)
            T_LW, T_SW: begin
               if (k == 2) begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
               else if (k == 3 && op == T_LW) o.iord = 1'b1;
               else if (k == 3) begin o.iord = 1'b1; o.memwrite = 1'b1; end
               else begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
            end
            T_RTYPE: begin
               if (k == 2) begin o.alusrca = 1'b1; o.aluop = 2'b10; end
               else begin o.regdst = 1'b1; o.regwrite = 1'b1; end
            end
            T_ADDI: begin
               if (k == 2) begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
               else o.regwrite = 1'b1;
            end
            T_BEQ: begin
               o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcen = z;
            end
            T_J: begin
               o.pcsrc = 2'b10; o.pcen = 1'b1;
            end
`ifdef MC_CTRL_BNE_EN
            T_BNE: begin
               o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcen = ~z;
            end
`endif
            default: o = '0;
         endcase
      end
      return o;
   endfunction

   task automatic step(input logic [5:0] op, input logic z, input logic rst, input int k);
      exp_t e;
      @(posedge clk);
      #1;
      reset    = rst;
      bus.op   = op;
      bus.zero = z;
      e.o   = ref_out(op, k, z);
      e.op  = op;
      e.k   = k;
      e.rst = rst;
      if (rst) begin
         e.o.pcen = 1'b0; e.o.irwrite = 1'b0; e.o.memwrite = 1'b0; e.o.regwrite = 1'b0;
      end
      exp_q.push_back(e);
   endtask

   // zmode: 0/1 fixed zero flag, 2 random; rst_k: step at which reset hits, -1 for none
   task automatic run_instr(input logic [5:0] op, input int zmode, input int rst_k);
      int n;
      logic z;
      n = ref_len(op);
      for (int k = 0; k < n; k++) begin
         z = (zmode == 2) ? 1'($urandom % 2) : (zmode == 1);
         step(op, z, (k == rst_k), k);
         if (k == rst_k) break;
      end
   endtask

   obs_t act;
   exp_t got;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         got = exp_q.pop_front();
         act = '{bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.iord, bus.memtoreg,
                 bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop};
         n_cmp++;
         if (act !== got.o) begin
            n_bad++;
            $display("FAIL ctrl op=%b step=%0d rst=%0b got=%b want=%b (pcen,ir,mw,rw,iord,m2r,rdst,srca,srcb,pcsrc,aluop)",
                     got.op, got.k, got.rst, act, got.o);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [5:0] op;
      int         sel;
      int         rk;
      reset    = 1'b1;
      bus.op   = '0;
      bus.zero = 1'b0;
      step(6'd0, 1'b0, 1'b1, 0);
      step(6'd0, 1'b0, 1'b1, 0);

      run_instr(T_LW,    0, -1);
      run_instr(T_SW,    2, -1);
      run_instr(T_RTYPE, 2, -1);
      run_instr(T_BEQ,   1, -1);
      run_instr(T_BEQ,   0, -1);
      run_instr(T_J,     2, -1);
      run_instr(6'h3f,   2, -1);
      run_instr(T_BNE,   0, -1);
      run_instr(T_BNE,   1, -1);
      run_instr(T_ADDI,  2, -1);
      run_instr(T_SW,    2, 3);
      run_instr(T_RTYPE, 2, 3);
      run_instr(T_LW,    1, 4);
      run_instr(T_J,     2, 2);

      for (int i = 0; i < 300; i++) begin
         sel = $urandom % 10;
         case (sel)
            0: op = T_LW;
            1: op = T_SW;
            2: op = T_RTYPE;
            3: op = T_BEQ;
            4: op = T_ADDI;
            5: op = T_J;
            6: op = T_BNE;
            7: op = 6'h3f;
            default: op = 6'($urandom % 64);
         endcase
         rk = ($urandom % 12 == 0) ? int'($urandom % ref_len(op)) : -1;
         run_instr(op, 2, rk);
      end

      repeat (2) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
